// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl (master) and the IFU/datapath side (slave).
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instruction;
    logic             pc_wr;
    logic [1:0]       nPC_sel;
    logic             j_sel;
    logic             ir_wr;
    logic             reg_wr;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [1:0]       ext_op;
    logic             mem_wr;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;
    logic             halted;

    modport master (
        input  instruction,
        output pc_wr, nPC_sel, j_sel, ir_wr, reg_wr, reg_dst, mem_to_reg,
               alu_src, alu_op, ext_op, mem_wr, state, instr_cnt, halted
    );

    modport slave (
        output instruction,
        input  pc_wr, nPC_sel, j_sel, ir_wr, reg_wr, reg_dst, mem_to_reg,
               alu_src, alu_op, ext_op, mem_wr, state, instr_cnt, halted
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore control unit for the MIPS-lite subset, fed by the IFU.
// Optional macro MC_CTRL_ILLEGAL_HALT_EN: illegal opcodes halt until reset.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXE     = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_HALT    = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } cls_e;

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;
    cls_e             cls;

    logic       pc_wr, j_sel, ir_wr, reg_wr, alu_src, mem_wr, halted;
    logic [1:0] nPC_sel, reg_dst, mem_to_reg, alu_op, ext_op;

    logic unused_ir;
    assign unused_ir = ^ir_q[25:6];

    always_comb begin
        cls = C_ILL;
        case (ir_q[31:26])
            6'b000000: begin
                if (ir_q[5:0] == 6'b100001)      cls = C_ADDU;
                else if (ir_q[5:0] == 6'b100011) cls = C_SUBU;
            end
            6'b001101: cls = C_ORI;
            6'b001111: cls = C_LUI;
            6'b100011: cls = C_LW;
            6'b101011: cls = C_SW;
            6'b000100: cls = C_BEQ;
            6'b000010: cls = C_J;
            6'b000011: cls = C_JAL;
            default:   cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ir_wr) ir_q  <= bus.instruction;
            if (pc_wr) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_wr      = 1'b0;
        nPC_sel    = 2'b00;
        j_sel      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        ext_op     = 2'b00;
        mem_wr     = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_EXE;
                    C_LW, C_SW:                   state_d = S_MEM_ADR;
                    C_BEQ:                        state_d = S_BRANCH;
                    C_J, C_JAL:                   state_d = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
                    default:                      state_d = S_HALT;
`else
                    default:                      state_d = S_JUMP;
`endif
                endcase
            end
            // ALU_WB reuses the EXE decode so the ALU controls stay stable into writeback
            S_EXE, S_ALU_WB: begin
                case (cls)
                    C_SUBU:  alu_op = 2'b01;
                    C_ORI: begin
                        alu_op  = 2'b10;
                        alu_src = 1'b1;
                    end
                    C_LUI: begin
                        alu_src = 1'b1;
                        ext_op  = 2'b10;
                    end
                    default: alu_op = 2'b00;
                endcase
                if (state_q == S_ALU_WB) begin
                    reg_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    reg_dst = (cls == C_ADDU || cls == C_SUBU) ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_MEM_ADR, S_MEM_RD, S_MEM_WR: begin
                alu_src = 1'b1;
                ext_op  = 2'b01;
                if (state_q == S_MEM_ADR) begin
                    state_d = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
                end else if (state_q == S_MEM_RD) begin
                    state_d = S_MEM_WB;
                end else begin
                    mem_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 2'b01;
                pc_wr      = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op  = 2'b01;
                ext_op  = 2'b01;
                nPC_sel = 2'b10;
                pc_wr   = 1'b1;
                state_d = S_FETCH;
            end
            // Illegal opcodes land here as a plain pc+4 step when halting is disabled
            S_JUMP: begin
                pc_wr = 1'b1;
                if (cls == C_J || cls == C_JAL) j_sel = 1'b1;
                if (cls == C_JAL) begin
                    reg_wr     = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = S_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.pc_wr      = pc_wr;
    assign bus.nPC_sel    = nPC_sel;
    assign bus.j_sel      = j_sel;
    assign bus.ir_wr      = ir_wr;
    assign bus.reg_wr     = reg_wr;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;
    assign bus.ext_op     = ext_op;
    assign bus.mem_wr     = mem_wr;
    assign bus.state      = state_q;
    assign bus.instr_cnt  = cnt_q;
    assign bus.halted     = halted;
endmodule
